// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: machine width, per-stage payload layouts and the
// helper that sizes the occupancy counter of stage_buf.
package pipe_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } aluOp_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } ifIdPayload_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1Val;
    logic [XLEN-1:0] rs2Val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    aluOp_t          aluOp;
  } idExPayload_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] storeData;
    logic [4:0]      rd;
    logic            memRead;
    logic            memWrite;
  } exMemPayload_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [4:0]      rd;
    logic            regWrite;
  } memWbPayload_t;

  // Payload widths used when placing stage_buf between ifu/idu/exu/mmu/wbu.
  localparam int IF_ID_WIDTH  = $bits(ifIdPayload_t);
  localparam int ID_EX_WIDTH  = $bits(idExPayload_t);
  localparam int EX_MEM_WIDTH = $bits(exMemPayload_t);
  localparam int MEM_WB_WIDTH = $bits(memWbPayload_t);

  // Occupancy must represent 0..depth inclusive.
  function automatic int countWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stage_buf_if.sv
// Valid/ready bundle between two pipeline stages, including flush and the
// buffer's occupancy report.
interface stage_buf_if
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int DEPTH      = 2
);

  logic                         flush;
  logic                         in_valid;
  logic                         in_ready;
  logic [DATA_WIDTH-1:0]        in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_WIDTH-1:0]        out_data;
  logic [countWidth(DEPTH)-1:0] count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/stage_buf_mem.sv
// Entry storage for stage_buf: one synchronous write port, one asynchronous
// read port.
module stage_buf_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                     clk,
  input  logic                     wrEn,
  input  logic [$clog2(DEPTH)-1:0] wrAddr,
  input  logic [DATA_WIDTH-1:0]    wrData,
  input  logic [$clog2(DEPTH)-1:0] rdAddr,
  output logic [DATA_WIDTH-1:0]    rdData
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage carries no reset; an entry is only ever read after the
  // pointers say it was written, so clearing it would just cost reset fan-out.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/stage_buf.sv
// Elastic pipeline-stage buffer: a small FIFO with optional zero-latency
// bypass when empty and a flush that empties it in one cycle.
module stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int DEPTH      = 2,
  parameter bit BYPASS     = 1'b0
) (
  input logic       clk,
  input logic       rst,
  stage_buf_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = countWidth(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0]         wrPtr;
  logic [PW-1:0]         rdPtr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] rdData;
  logic                  isEmpty;
  logic                  push;
  logic                  pop;
  logic                  passThru;
  logic                  store;
  logic                  memPop;

  assign isEmpty = (count == '0);

  // in_ready depends on the occupancy register alone, so out_ready never
  // reaches it combinationally; a pop while full frees space next cycle.
  assign bus.in_ready  = (count != FULL);
  assign bus.out_valid = !bus.flush && (!isEmpty || (BYPASS && bus.in_valid));
  assign bus.out_data  = (BYPASS && isEmpty) ? bus.in_data : rdData;
  assign bus.count     = count;

  assign push = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

  // A bypassed word consumed in the same cycle never touches storage.
  assign passThru = BYPASS && isEmpty && push && pop;
  assign store    = push && !passThru;
  assign memPop   = pop && !isEmpty;

  // Reset and flush both collapse to the empty state; reset simply wins first.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (store) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (memPop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      count <= count + CW'(store) - CW'(memPop);
    end
  end

  stage_buf_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk   (clk),
    .wrEn  (store),
    .wrAddr(wrPtr),
    .wrData(bus.in_data),
    .rdAddr(rdPtr),
    .rdData(rdData)
  );

endmodule

// File: tb/tb_stage_buf.sv
// Self-checking bench for stage_buf: three configurations share one stimulus
// stream, each with its own queue-based reference model and monitor.
module tb_stage_buf;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          inValid;
  logic [DW-1:0] inData;
  logic          outReady;

  int topChecks = 0;
  int topErrs   = 0;

  always #5 clk = ~clk;

  // Instance 0: DEPTH=2 no bypass; 1: DEPTH=4 no bypass; 2: DEPTH=4 bypass.
  for (genvar g = 0; g < 3; g++) begin : gInst
    localparam int D = (g == 0) ? 2 : 4;
    localparam bit B = (g == 2);

    stage_buf_if #(.DATA_WIDTH(DW), .DEPTH(D)) bus ();

    assign bus.flush     = flush;
    assign bus.in_valid  = inValid;
    assign bus.in_data   = inData;
    assign bus.out_ready = outReady;

    stage_buf #(.DATA_WIDTH(DW), .DEPTH(D), .BYPASS(B)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
    );

    logic [DW-1:0] sbQ[$];
    int  checks = 0;
    int  errs   = 0;
    bit  armed  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
        errs++;
        $display("FAIL inst%0d %s: got 0x%0h, expected 0x%0h at %0t", g, name, act, exp, $time);
      end
    endtask

    // Model: the buffer is an ordered queue of at most D words; whatever is
    // accepted comes out in order, flush/reset empty it.
    always @(negedge clk) begin
      bit            expValid;
      logic [DW-1:0] expData;
      expValid = !flush && (sbQ.size() != 0 || (B && inValid));
      if (sbQ.size() != 0) expData = sbQ[0];
      else                 expData = inData;

      if (armed) begin
        check("count", 32'(bus.count), 32'(sbQ.size()));
        check("in_ready", 32'(bus.in_ready), 32'(sbQ.size() != D));
        check("out_valid", 32'(bus.out_valid), 32'(expValid));
        if (expValid) check("out_data", 32'(bus.out_data), 32'(expData));
      end

      if (rst) begin
        sbQ.delete();
        armed = 1'b1;
      end else if (flush) begin
        sbQ.delete();
      end else begin
        if (inValid && sbQ.size() != D) sbQ.push_back(inData);
        if (expValid && outReady) void'(sbQ.pop_front());
      end
    end
  end

  task automatic checkTop(input string name, input logic [31:0] act, input logic [31:0] exp);
    topChecks++;
    if (act !== exp) begin
      topErrs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    checkTop("reset count", 32'(gInst[1].bus.count), 0);
    checkTop("reset out_valid", 32'(gInst[1].bus.out_valid), 0);
    checkTop("reset in_ready", 32'(gInst[1].bus.in_ready), 1);

    // Fill a DEPTH=2 buffer with 0xA, 0xB, then drain it.
    tick();
    inValid = 1'b1; inData = 16'hA;
    tick();
    inData = 16'hB;
    tick();
    inValid = 1'b0;
    @(negedge clk);
    checkTop("fill count", 32'(gInst[0].bus.count), 2);
    checkTop("fill in_ready", 32'(gInst[0].bus.in_ready), 0);
    tick();
    outReady = 1'b1;
    @(negedge clk);
    checkTop("drain first", 32'(gInst[0].bus.out_data), 32'hA);
    tick();
    @(negedge clk);
    checkTop("drain second", 32'(gInst[0].bus.out_data), 32'hB);
    tick();
    @(negedge clk);
    checkTop("drain count", 32'(gInst[0].bus.count), 0);

    // Bypass: same-cycle pass-through, then store when downstream stalls.
    tick();
    inValid = 1'b1; inData = 16'h1234;
    @(negedge clk);
    checkTop("bypass out_valid", 32'(gInst[2].bus.out_valid), 1);
    checkTop("bypass out_data", 32'(gInst[2].bus.out_data), 32'h1234);
    tick();
    inValid = 1'b0;
    @(negedge clk);
    checkTop("bypass count", 32'(gInst[2].bus.count), 0);
    tick();
    inValid = 1'b1; outReady = 1'b0;
    tick();
    inValid = 1'b0;
    @(negedge clk);
    checkTop("bypass stall count", 32'(gInst[2].bus.count), 1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; outReady = 1'b1;

    // Streaming 1..100 through DEPTH=4, one cycle behind the input.
    for (int i = 1; i <= 100; i++) begin
      inValid = 1'b1; inData = DW'(i);
      @(negedge clk);
      if (i > 1) checkTop("stream data", 32'(gInst[1].bus.out_data), 32'(i - 1));
      tick();
    end
    inValid = 1'b0;
    @(negedge clk);
    checkTop("stream count", 32'(gInst[1].bus.count), 1);
    repeat (4) tick();

    // Flush with 0x55 on the input while three entries are held.
    outReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      inValid = 1'b1; inData = DW'(16'h10 + k);
      tick();
    end
    inValid = 1'b0;
    @(negedge clk);
    checkTop("pre-flush count", 32'(gInst[1].bus.count), 3);
    tick();
    flush = 1'b1; inValid = 1'b1; inData = 16'h55;
    @(negedge clk);
    checkTop("flush out_valid", 32'(gInst[1].bus.out_valid), 0);
    checkTop("flush bypass out_valid", 32'(gInst[2].bus.out_valid), 0);
    tick();
    @(negedge clk);
    checkTop("flush count", 32'(gInst[1].bus.count), 0);
    tick();
    flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
    @(negedge clk);
    checkTop("post-flush count", 32'(gInst[2].bus.count), 0);

    // Reset with two entries held.
    tick();
    outReady = 1'b0;
    inValid = 1'b1; inData = 16'h77;
    tick();
    inData = 16'h78;
    tick();
    inValid = 1'b0;
    @(negedge clk);
    checkTop("pre-reset count", 32'(gInst[1].bus.count), 2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkTop("mid reset count", 32'(gInst[1].bus.count), 0);
    checkTop("mid reset out_valid", 32'(gInst[1].bus.out_valid), 0);
    checkTop("mid reset in_ready", 32'(gInst[1].bus.in_ready), 1);
    tick();
    outReady = 1'b1;

    // Random traffic with alternating stall-heavy and drain-heavy phases.
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst      = ($urandom_range(0, 399) == 0);
      flush    = ($urandom_range(0, 49) == 0);
      inValid  = ($urandom_range(0, 3) != 0);
      inData   = DW'($urandom);
      outReady = ((n / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                      : ($urandom_range(0, 3) != 0);
    end
    tick();
    rst = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             topChecks + gInst[0].checks + gInst[1].checks + gInst[2].checks,
             topErrs + gInst[0].errs + gInst[1].errs + gInst[2].errs);
    $finish;
  end

endmodule
